// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the IF/MEM memory-port arbiter: FSM states, owner tags,
// and the width of the fetch starvation counter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch stage, the memory stage, the arbiter and memory.
// master = the arbiter's view; slave = the requesters plus the memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_be;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_W-1:0]     d_rdata;

    logic                  m_req;
    logic                  m_we;
    logic [ADDR_W-1:0]     m_addr;
    logic [DATA_W-1:0]     m_wdata;
    logic [DATA_W/8-1:0]   m_be;
    logic                  m_gnt;
    logic                  m_rvalid;
    logic [DATA_W-1:0]     m_rdata;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
        input  m_gnt, m_rvalid, m_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output m_req, m_we, m_addr, m_wdata, m_be
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
        output m_gnt, m_rvalid, m_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  m_req, m_we, m_addr, m_wdata, m_be
    );

endinterface

// File: rtl/mem_port_arbiter_prio_sel.sv
// Winner select for the IDLE decision plus the next value of the fetch
// starvation counter; data wins unless fetch has waited STARVE_LIMIT times.
module mem_port_arbiter_prio_sel
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic             i_if_req,
    input  logic             i_d_req,
    input  logic [CNT_W-1:0] i_starve_cnt,
    output logic             o_win_any,
    output owner_e           o_winner,
    output logic [CNT_W-1:0] o_starve_nxt
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic w_force_if;

    assign w_force_if = i_if_req && (i_starve_cnt == LIMIT);

    always_comb begin
        o_win_any    = i_if_req | i_d_req;
        o_winner     = OWN_IF;
        o_starve_nxt = '0;
        if (i_d_req && !w_force_if) begin
            o_winner = OWN_D;
            // Only a data win that leaves fetch waiting counts toward starvation.
            if (i_if_req) begin
                o_starve_nxt = (i_starve_cnt >= LIMIT) ? LIMIT : i_starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data requests onto one single-ported memory with at most
// one transaction in flight, steering grant/response pulses back to the owner.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.master  bus,
    output logic                busy
);

    arb_state_e            r_state;
    owner_e                r_owner;
    logic [CNT_W-1:0]      r_starve_cnt;
    logic                  r_m_req;
    logic                  r_m_we;
    logic [ADDR_W-1:0]     r_m_addr;
    logic [DATA_W-1:0]     r_m_wdata;
    logic [DATA_W/8-1:0]   r_m_be;

    logic                  w_win_any;
    owner_e                w_winner;
    logic [CNT_W-1:0]      w_starve_nxt;
    logic                  w_issue;
    logic                  w_wait;

    mem_port_arbiter_prio_sel #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio_sel (
        .i_if_req     (bus.if_req),
        .i_d_req      (bus.d_req),
        .i_starve_cnt (r_starve_cnt),
        .o_win_any    (w_win_any),
        .o_winner     (w_winner),
        .o_starve_nxt (w_starve_nxt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ARB_IDLE;
            r_owner      <= OWN_IF;
            r_starve_cnt <= '0;
            r_m_req      <= 1'b0;
            r_m_we       <= 1'b0;
            r_m_addr     <= '0;
            r_m_wdata    <= '0;
            r_m_be       <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    r_starve_cnt <= w_starve_nxt;
                    if (w_win_any) begin
                        r_owner <= w_winner;
                        r_m_req <= 1'b1;
                        r_state <= ARB_ISSUE;
                        if (w_winner == OWN_D) begin
                            r_m_we    <= bus.d_we;
                            r_m_addr  <= bus.d_addr;
                            r_m_wdata <= bus.d_wdata;
                            r_m_be    <= bus.d_be;
                        end else begin
                            r_m_we    <= 1'b0;
                            r_m_addr  <= bus.if_addr;
                            r_m_wdata <= '0;
                            r_m_be    <= '1;
                        end
                    end
                end
                ARB_ISSUE: begin
                    if (bus.m_gnt) begin
                        r_m_req <= 1'b0;
                        r_state <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (bus.m_rvalid) begin
                        r_state <= ARB_IDLE;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    // Qualifying by state keeps stray m_gnt/m_rvalid from reaching a requester.
    assign w_issue = (r_state == ARB_ISSUE);
    assign w_wait  = (r_state == ARB_WAIT);

    assign bus.if_gnt    = bus.m_gnt    & w_issue & (r_owner == OWN_IF);
    assign bus.d_gnt     = bus.m_gnt    & w_issue & (r_owner == OWN_D);
    assign bus.if_rvalid = bus.m_rvalid & w_wait  & (r_owner == OWN_IF);
    assign bus.d_rvalid  = bus.m_rvalid & w_wait  & (r_owner == OWN_D);
    assign bus.if_rdata  = bus.m_rdata;
    assign bus.d_rdata   = bus.m_rdata;

    assign bus.m_req   = r_m_req;
    assign bus.m_we    = r_m_we;
    assign bus.m_addr  = r_m_addr;
    assign bus.m_wdata = r_m_wdata;
    assign bus.m_be    = r_m_be;

    assign busy = (r_state != ARB_IDLE);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported unified instruction/data memory of the RV32I pipelined CPU between the fetch stage (IF) and the memory stage (MEM). Each requester uses a req/gnt/rvalid handshake. The arbiter serialises requests onto one memory port with at most one transaction outstanding, and routes each response back to its owner. Data accesses have priority; a starvation counter guarantees instruction-fetch forward progress.

## Interface
- `ADDR_W`, 32, address width in bits
- `DATA_W`, 32, data width in bits
- `STARVE_LIMIT`, 4, consecutive data grants with `if_req` pending before fetch is forced to win; range 1..15

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch request; held with `if_addr` until `if_gnt`
- `if_addr`  in  ADDR_W  fetch word address
- `if_gnt`  out  1  fetch request accepted by memory (1-cycle pulse)
- `if_rvalid`  out  1  fetch read data valid (1-cycle pulse)
- `if_rdata`  out  DATA_W  fetch read data
- `d_req`  in  1  data request; held with its fields until `d_gnt`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_be`  in  DATA_W/8  byte enables
- `d_gnt`  out  1  data request accepted (1-cycle pulse)
- `d_rvalid`  out  1  load data valid or store acknowledge (1-cycle pulse)
- `d_rdata`  out  DATA_W  load data
- `m_req`, `m_we`, `m_addr`, `m_wdata`, `m_be`  out  1/1/ADDR_W/DATA_W/DATA_W/8  memory request; all registered
- `m_gnt`  in  1  memory accepted the request
- `m_rvalid`  in  1  memory response; also returned for stores
- `m_rdata`  in  DATA_W  memory read data
- `busy`  out  1  state is not IDLE

## Operation
- FSM states:
  - IDLE: if any request is present, latch the winner's fields into the `m_*` registers, set `owner`, and go to ISSUE.
  - ISSUE: assert `m_req` and hold it until `m_gnt`. On `m_gnt`, pulse the owner's `x_gnt`, drop `m_req`, and go to WAIT_RSP.
  - WAIT_RSP: on `m_rvalid`, pulse the owner's `x_rvalid` and go to IDLE.
- Winner selection in IDLE:
  - Only `d_req` set: data wins.
  - Only `if_req` set: fetch wins.
  - Both set: data wins unless `starve_cnt == STARVE_LIMIT`, in which case fetch wins.
- `starve_cnt` (4 bits):
  - Increments on each data win while `if_req` = 1.
  - Clears on any fetch win, and in IDLE when `if_req` = 0.
  - Saturates at `STARVE_LIMIT`.
- `if_rdata`/`d_rdata` carry `m_rdata` unconditionally; they are qualified only by `x_rvalid`.
- `x_gnt`/`x_rvalid` are combinational from `m_gnt`/`m_rvalid` AND `owner`. `m_rvalid` is ignored outside WAIT_RSP.
- A request dropped by a requester after IDLE has latched it is still completed; the response is delivered regardless. Requesters must not do this.
- Reset (asynchronous, any state):
  - state goes to IDLE, `starve_cnt` = 0, `owner` = fetch
  - all `m_*` outputs = 0, `busy` = 0, all `x_gnt`/`x_rvalid` = 0
  - any in-flight response is discarded.

## Timing
- Request sampled in IDLE at cycle N; `m_req` is high from cycle N+1.
- `m_gnt` in cycle N+1 gives `x_gnt` in cycle N+1.
- `m_rvalid` at cycle N+2 at the earliest gives `x_rvalid` at N+2.
- Back in IDLE at N+3: 3-cycle issue period per transaction at zero memory wait.
- `m_gnt` and `m_rvalid` in the same cycle is illegal for the memory; the arbiter treats it as `m_gnt` only.
- `m_addr`/`m_wdata`/`m_be`/`m_we` are stable from entry to ISSUE until `m_gnt`.

## Structure
- Shared package/header `define.vh` holds:
  - state encodings `ARB_IDLE`=2'd0, `ARB_ISSUE`=2'd1, `ARB_WAIT`=2'd2
  - owner encodings `OWN_IF`=1'b0, `OWN_D`=1'b1
- One optional sub-module `arb_prio_sel`: combinational winner select plus starvation-counter update. Everything else is flat.

## Test plan
- Reset asserted while in WAIT_RSP with a load outstanding → all outputs read 0. A late `m_rvalid` produces no `d_rvalid`. `busy` = 0.
- Single fetch of 0x0000_0010, memory `m_gnt` at +0 and `m_rdata`=0x0000_0513 at +1 → `if_gnt` in cycle 1, `if_rvalid` with 0x0000_0513 in cycle 2, `busy` low in cycle 3.
- `if_req` and `d_req` (load 0x100) both set in the same cycle → data is served first, fetch second, `starve_cnt` = 0 after the fetch grant.
- `d_req` held continuously with `if_req` pending and `STARVE_LIMIT`=4 → exactly 4 data grants, then 1 fetch grant, then the pattern repeats.
- Store with `d_be`=4'b0011, `d_wdata`=0xDEAD_BEEF, memory inserting 3 wait cycles before `m_gnt` → `m_*` fields stable for all 4 cycles. `d_rvalid` pulses once on the store acknowledge; `if_rvalid` never pulses.
- Spurious `m_rvalid` while in IDLE or ISSUE → ignored, no `x_rvalid` pulse.
